// File: rtl/trap_controller.sv
// trap_controller: sequences trap entry -- TT latch, PSR update, PC/nPC save, fetch redirect.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   exc_req[6:0]     synchronous exception requests, bit 0 has the highest priority
//   ticc_req         Ticc taken; ticc_num is its software trap number
//   irl, pil, et     interrupt level, PSR interrupt level, PSR enable-traps
//   cwp_in           current window pointer
//   tt_out, tt_wr    latched trap type and its TBR write strobe
//   psr_trap_wr      PSR update strobe; cwp_next is the decremented window pointer
//   reg_wr, reg_sel  local register write strobe; reg_sel 0 = PC->r17, 1 = nPC->r18
//   redirect         fetch from the trap vector
//   trap_ack         request consumed
//   busy             pipeline stall
//   error_mode       halted after a synchronous trap with traps disabled
module trap_controller #(
    parameter int NWINDOWS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] exc_req,
    input  logic       ticc_req,
    input  logic [6:0] ticc_num,
    input  logic [3:0] irl,
    input  logic [3:0] pil,
    input  logic       et,
    input  logic [4:0] cwp_in,
    output logic [7:0] tt_out,
    output logic       tt_wr,
    output logic       psr_trap_wr,
    output logic [4:0] cwp_next,
    output logic       reg_wr,
    output logic       reg_sel,
    output logic       redirect,
    output logic       trap_ack,
    output logic       busy,
    output logic       error_mode
);
    typedef enum logic [2:0] {IDLE, TTWR, PSRW, SAVEPC, SAVENPC, REDIR, ERROR} state_t;
    state_t state, state_nx;
    logic [7:0] tt_sel;
    logic sync_req, irq_ok;
    assign sync_req = |exc_req || ticc_req;
    assign irq_ok = et && irl != 4'd0 && (irl > pil || irl == 4'hF);
    // Lowest-priority source first so that higher-priority sources overwrite it.
    always_comb begin
        tt_sel = {4'h1, irl};
        if (ticc_req) tt_sel = {1'b1, ticc_num};
        for (int i = 6; i >= 0; i--)
            if (exc_req[i]) tt_sel = 8'(i + 1);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        tt_wr = 1'b0;
        psr_trap_wr = 1'b0;
        reg_wr = 1'b0;
        reg_sel = 1'b0;
        redirect = 1'b0;
        trap_ack = 1'b0;
        error_mode = 1'b0;
        busy = state != IDLE;
        case (state)
            IDLE: begin
                // A synchronous trap with traps disabled halts the processor.
                if (sync_req && !et) state_nx = ERROR;
                else if (sync_req || irq_ok) state_nx = TTWR;
            end
            TTWR: begin
                tt_wr = 1'b1;
                state_nx = PSRW;
            end
            PSRW: begin
                psr_trap_wr = 1'b1;
                state_nx = SAVEPC;
            end
            SAVEPC: begin
                reg_wr = 1'b1;
                state_nx = SAVENPC;
            end
            SAVENPC: begin
                reg_wr = 1'b1;
                reg_sel = 1'b1;
                state_nx = REDIR;
            end
            REDIR: begin
                redirect = 1'b1;
                trap_ack = 1'b1;
                state_nx = IDLE;
            end
            ERROR: error_mode = 1'b1;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_out <= 8'h00;
            cwp_next <= 5'd0;
        end else begin
            if (state == IDLE && state_nx == TTWR) tt_out <= tt_sel;
            // Captured as PSRW is entered so psr_trap_wr sees a stable value.
            if (state == TTWR)
                cwp_next <= (cwp_in == 5'd0) ? 5'(NWINDOWS - 1) : cwp_in - 5'd1;
        end
    end
endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter NWINDOWS, default 8, meaning the number of register windows used for CWP wrap.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port exc_req, input, 7 bits: synchronous exception requests, held by the pipeline until trap_ack.
REQ-005 SHALL have port ticc_req, input, 1 bit: Ticc taken, held until trap_ack.
REQ-006 SHALL have port ticc_num, input, 7 bits: Ticc software trap number.
REQ-007 SHALL have port irl, input, 4 bits: external interrupt request level.
REQ-008 SHALL have port pil, input, 4 bits: PSR processor interrupt level.
REQ-009 SHALL have port et, input, 1 bit: PSR enable-traps.
REQ-010 SHALL have port cwp_in, input, 5 bits: current window pointer.
REQ-011 SHALL have port tt_out, output, 8 bits: latched trap type to the TBR TT field.
REQ-012 SHALL have port tt_wr, output, 1 bit: TT write strobe to the TBR.
REQ-013 SHALL have port psr_trap_wr, output, 1 bit: PSR update strobe (S<=1, PS<=S, ET<=0, CWP<=cwp_next).
REQ-014 SHALL have port cwp_next, output, 5 bits: the new CWP value.
REQ-015 SHALL have port reg_wr, output, 1 bit: local-register write strobe.
REQ-016 SHALL have port reg_sel, output, 1 bit: 0 selects PC->r17, 1 selects nPC->r18.
REQ-017 SHALL have port redirect, output, 1 bit: fetch from {TBA, tt_out, 4'b0}.
REQ-018 SHALL have port trap_ack, output, 1 bit: request consumed.
REQ-019 SHALL have port busy, output, 1 bit: stall the pipeline.
REQ-020 SHALL have port error_mode, output, 1 bit: processor halted in error mode.

Function
REQ-021 SHALL implement states IDLE, TTWR, PSRW, SAVEPC, SAVENPC, REDIR, ERROR.
REQ-022 SHALL sample requests only in IDLE; requests arriving in any other state are ignored.
REQ-023 SHALL select by fixed priority: exc_req[0] highest through exc_req[6], then ticc_req, then interrupt.
REQ-024 SHALL map TT as: exc_req[n] -> n+1 (0x01..0x07); Ticc -> 0x80+ticc_num; interrupt -> 0x10+irl.
REQ-025 SHALL qualify an interrupt only when et=1, irl!=0, and (irl>pil or irl==15).
REQ-026 SHALL, in IDLE with a qualified exception/Ticc/interrupt and et=1, latch tt_out and move to TTWR.
REQ-027 SHALL, in IDLE with any exc_req or ticc_req and et=0, move to ERROR, leaving tt_out unchanged.
REQ-028 SHALL drive the sequence TTWR (tt_wr=1) -> PSRW (psr_trap_wr=1) -> SAVEPC (reg_wr=1, reg_sel=0) -> SAVENPC (reg_wr=1, reg_sel=1) -> REDIR (redirect=1, trap_ack=1) -> IDLE, one cycle each.
REQ-029 SHALL assert each strobe for exactly one cycle per trap.
REQ-030 SHALL produce redirect 5 cycles after the IDLE sampling edge.
REQ-031 SHALL compute cwp_next = cwp_in-1, wrapping 0 -> NWINDOWS-1, registered on entry to PSRW and held stable until the next trap.
REQ-032 SHALL assert busy in every state except IDLE, and hold it in ERROR.
REQ-033 SHALL make ERROR absorbing: error_mode=1, busy=1, all strobes 0, exit only via rst.
REQ-034 SHALL make tt_out change only on the IDLE->TTWR transition.

Reset
REQ-035 SHALL, on rst=1 at a clk edge (overriding all else, including mid-sequence), enter IDLE with tt_out=0, cwp_next=0, and all strobes, busy and error_mode at 0.

Verification
REQ-036 Bench SHALL drive exc_req=7'b0000100 with et=1 -> tt_out=0x03; tt_wr, psr_trap_wr, reg_wr(sel0), reg_wr(sel1), redirect on 5 consecutive cycles.
REQ-037 Bench SHALL drive exc_req=7'b1000010, ticc_req=1, irl=15 together -> tt_out=0x02 only.
REQ-038 Bench SHALL drive irl=5, pil=5, et=1 -> no trap; then irl=15, pil=15 -> tt_out=0x1F.
REQ-039 Bench SHALL drive cwp_in=0, NWINDOWS=8, ticc_num=0x05 -> cwp_next=7 and tt_out=0x85.
REQ-040 Bench SHALL drive exc_req[4]=1 with et=0 -> error_mode=1 held; an irl=15 request with et=0 alone -> ignored.
REQ-041 Bench SHALL assert rst during SAVEPC -> next cycle IDLE, busy=0, tt_out=0, no redirect.
